// File: rtl/arb8_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb8_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   function automatic logic [N_REQ-1:0] onehot8(input logic [ID_W-1:0] id, input logic en);
      return en ? (8'b1 << id) : 8'b0;
   endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational round-robin search: first set request after last_id, wrapping,
// with one optional requester masked out.
module rr_pick_8
   import arb8_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_id,
   input  logic             excl_en,
   input  logic [ID_W-1:0]  excl_id,
   output logic             any,
   output logic [ID_W-1:0]  pick_id
);

   logic [N_REQ-1:0] req_m;

   assign req_m = req & ~onehot8(excl_id, excl_en);

   always_comb begin
      logic [ID_W-1:0] idx;
      any     = 1'b0;
      pick_id = '0;
      idx     = '0;
      // Offsets 1..8 visit last_id itself last, so it has the lowest priority.
      for (int k = 1; k <= N_REQ; k++) begin
         idx = last_id + ID_W'(k);
         if (req_m[idx] && !any) begin
            any     = 1'b1;
            pick_id = idx;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered index/one-hot grant.
// Define ARB_PREEMPT_EN to force a hand-over after MAX_HOLD consecutive grant cycles.
module rr_arbiter_8
   import arb8_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_valid
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_param
      $error("rr_arbiter_8: illegal MAX_HOLD/HOLD_W combination");
   end

   arb_state_t      state;
   logic [ID_W-1:0] last_id;
   logic            pick_any;
   logic [ID_W-1:0] pick_id;
   logic            take;
   logic            drop;

`ifdef ARB_PREEMPT_EN
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_inc;
`endif

   // While busy the owner is masked, so a re-pick always moves to someone else.
   rr_pick_8 u_pick (
      .req     (req),
      .last_id (last_id),
      .excl_en (state == BUSY),
      .excl_id (gnt_id),
      .any     (pick_any),
      .pick_id (pick_id)
   );

   always_comb begin
      take = 1'b0;
      drop = 1'b0;
`ifdef ARB_PREEMPT_EN
      hold_inc = 1'b0;
`endif
      case (state)
         IDLE: take = pick_any;
         BUSY: begin
            if (req[gnt_id]) begin
`ifdef ARB_PREEMPT_EN
               if (hold_cnt == HOLD_LAST) take = pick_any;
               else                       hold_inc = 1'b1;
`endif
            end else if (pick_any) begin
               take = 1'b1;
            end else begin
               drop = 1'b1;
            end
         end
         default: drop = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
         last_id   <= 3'd7;
`ifdef ARB_PREEMPT_EN
         hold_cnt  <= '0;
`endif
      end else begin
         if (take) begin
            state     <= BUSY;
            gnt       <= onehot8(pick_id, 1'b1);
            gnt_id    <= pick_id;
            gnt_valid <= 1'b1;
            last_id   <= pick_id;
`ifdef ARB_PREEMPT_EN
            hold_cnt  <= '0;
`endif
         end else if (drop) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
         end
`ifdef ARB_PREEMPT_EN
         if (hold_inc) hold_cnt <= hold_cnt + 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed testbench for rr_arbiter_8 with immediate-assertion checks.
module tb_rr_arbiter_8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;

   int tests;
   int fails;

   rr_arbiter_8 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_grant(input string tag, input logic [2:0] id);
      chk({tag, "_valid"}, {31'd0, gnt_valid}, 32'd1);
      chk({tag, "_id"}, {29'd0, gnt_id}, {29'd0, id});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Grant vector must always equal the gated decode of the index.
   always @(negedge clk) begin
      if (rst_n) begin
         logic [7:0] dec;
         dec = gnt_valid ? (8'b1 << gnt_id) : 8'b0;
         chk("onehot_consistency", {24'd0, gnt}, {24'd0, dec});
         if (!gnt_valid) chk("idle_id_zero", {29'd0, gnt_id}, 32'd0);
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      req   = 8'h00;

      // Reset state
      tick();
      chk("rst_gnt", {24'd0, gnt}, 32'd0);
      chk("rst_id", {29'd0, gnt_id}, 32'd0);
      chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_no_req", {31'd0, gnt_valid}, 32'd0);

      // Single request, one-cycle latency, release to idle
      req = 8'h01;
      tick();
      chk("single_gnt", {24'd0, gnt}, 32'h01);
      chk_grant("single", 3'd0);
      req = 8'h00;
      tick();
      chk("release_gnt", {24'd0, gnt}, 32'd0);
      chk("release_valid", {31'd0, gnt_valid}, 32'd0);

      // Single requester re-wins right after releasing
      req = 8'h01;
      tick();
      chk_grant("rewin", 3'd0);

      // Full rotation with all requesting, no idle bubble between owners
      do_reset();
      req = 8'hFF;
      tick();
      chk_grant("rot_first", 3'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk_grant("rot_hold", 3'(k));
         req = 8'hFF & ~(8'h01 << k);
         tick();
         chk_grant("rot_next", 3'((k + 1) % 8));
         req = 8'hFF;
      end

      // Simultaneous owner drop and new requests, then wrap
      do_reset();
      req = 8'h08;
      tick();
      chk_grant("swap_first", 3'd3);
      req = 8'h82;
      tick();
      chk_grant("swap_to7", 3'd7);
      chk("swap_gnt", {24'd0, gnt}, 32'h80);
      req = 8'h02;
      tick();
      chk_grant("swap_wrap1", 3'd1);

      // Asynchronous reset in the middle of a grant
      do_reset();
      req = 8'h20;
      tick();
      chk_grant("mid_first", 3'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_gnt", {24'd0, gnt}, 32'd0);
      chk("async_valid", {31'd0, gnt_valid}, 32'd0);
      chk("async_id", {29'd0, gnt_id}, 32'd0);
      req = 8'h21;
      tick();
      rst_n = 1'b1;
      tick();
      chk_grant("post_rst_ptr", 3'd0);

      // Long contention between requesters 0 and 1
      do_reset();
      req = 8'h03;
`ifdef ARB_PREEMPT_EN
      for (int i = 0; i < 16; i++) begin
         tick();
         chk_grant("preempt_seq", 3'((i / 4) % 2));
      end
      req = 8'h01;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_grant("preempt_alone", 3'd0);
      end
`else
      for (int i = 0; i < 100; i++) begin
         tick();
         chk_grant("no_preempt", 3'd0);
      end
`endif

      req = 8'h00;
      tick();
      chk("final_idle", {31'd0, gnt_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
